// File: rtl/striping_pkg.sv
// Shared constants and types for the striping / un_striping lane pair.
package striping_pkg;
  localparam int DATA_W_DEF = 32;
  localparam logic LANE_0 = 1'b0;
  localparam logic LANE_1 = 1'b1;
  typedef logic [DATA_W_DEF-1:0] lane_word_t;
endpackage

// File: rtl/striping_lane_reg.sv
// One lane register plus valid: written when selected, cleared by synchronous active-low reset.
module lane_reg
  import striping_pkg::*;
#(
  parameter int W = DATA_W_DEF
) (
  input  logic         clk_2f,
  input  logic         reset,
  input  logic         i_we,
  input  logic         i_valid,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_data,
  output logic         o_valid
);
  logic [W-1:0] r_data;
  logic         r_valid;

  // An idle slot writes zero so a deasserted valid never carries a stale word.
  always_ff @(posedge clk_2f) begin
    if (!reset) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (i_we) begin
      r_data  <= i_valid ? i_data : '0;
      r_valid <= i_valid;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;
endmodule

// File: rtl/striping.sv
// Two-lane word striper: alternate words go to lane_0 / lane_1 on a free-running phase.
// Optional accepted-word counter enabled by STRIPING_WORD_CNT_EN.
module striping
  import striping_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
`ifdef STRIPING_WORD_CNT_EN
  ,
  parameter int CNT_W = 16
`endif
) (
  input  logic              clk_2f,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  output logic [DATA_W-1:0] lane_0,
  output logic              valid_0,
  output logic [DATA_W-1:0] lane_1,
  output logic              valid_1,
  output logic              phase
`ifdef STRIPING_WORD_CNT_EN
  ,
  output logic [CNT_W-1:0]  word_count
`endif
);
  logic r_sel;
  logic w_we_0;
  logic w_we_1;

  // Phase runs regardless of valid_in; un_striping relies on the same free-running phase.
  always_ff @(posedge clk_2f) begin
    if (!reset) r_sel <= LANE_0;
    else        r_sel <= ~r_sel;
  end

  assign w_we_0 = (r_sel == LANE_0);
  assign w_we_1 = (r_sel == LANE_1);
  assign phase  = r_sel;

  lane_reg #(.W(DATA_W)) u_lane_0 (
    .clk_2f  (clk_2f),
    .reset   (reset),
    .i_we    (w_we_0),
    .i_valid (valid_in),
    .i_data  (data_in),
    .o_data  (lane_0),
    .o_valid (valid_0)
  );

  lane_reg #(.W(DATA_W)) u_lane_1 (
    .clk_2f  (clk_2f),
    .reset   (reset),
    .i_we    (w_we_1),
    .i_valid (valid_in),
    .i_data  (data_in),
    .o_data  (lane_1),
    .o_valid (valid_1)
  );

`ifdef STRIPING_WORD_CNT_EN
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk_2f) begin
    if (!reset)        r_cnt <= '0;
    else if (valid_in) r_cnt <= r_cnt + CNT_W'(1);
  end

  assign word_count = r_cnt;
`endif
endmodule

// File: tb/tb_striping.sv
// Bench for striping: stream-history model checked every cycle plus literal anchors.
module tb_striping;
  import striping_pkg::*;

  logic       clk_2f = 1'b0;
  logic       reset;
  lane_word_t data_in;
  logic       valid_in;
  lane_word_t lane_0, lane_1;
  logic       valid_0, valid_1, phase;
`ifdef STRIPING_WORD_CNT_EN
  logic [15:0] word_count;
`endif

  always #5 clk_2f = ~clk_2f;

  striping dut (
    .clk_2f   (clk_2f),
    .reset    (reset),
    .data_in  (data_in),
    .valid_in (valid_in),
    .lane_0   (lane_0),
    .valid_0  (valid_0),
    .lane_1   (lane_1),
    .valid_1  (valid_1),
    .phase    (phase)
`ifdef STRIPING_WORD_CNT_EN
    ,
    .word_count (word_count)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: every post-reset edge consumes one stream slot; slot i belongs to lane i%2.
  typedef struct {
    bit         v;
    lane_word_t d;
  } ent_t;

  ent_t        hist[$];
  bit          armed = 1'b0;
  int unsigned mcnt  = 0;

  always @(posedge clk_2f) begin
    if (reset === 1'b0) begin
      hist.delete();
      mcnt  = 0;
      armed = 1'b1;
    end else if (armed) begin
      hist.push_back('{valid_in, data_in});
      if (valid_in) mcnt++;
    end
  end

  function automatic void lane_exp(input int k, output bit v, output lane_word_t d);
    int n;
    v = 1'b0;
    d = '0;
    n = hist.size();
    for (int i = n - 1; i >= 0 && i >= n - 2; i--) begin
      if ((i % 2) == k) begin
        v = hist[i].v;
        d = hist[i].v ? hist[i].d : '0;
      end
    end
  endfunction

  always @(negedge clk_2f) begin
    bit ev0, ev1;
    lane_word_t ed0, ed1;
    if (armed) begin
      lane_exp(0, ev0, ed0);
      lane_exp(1, ev1, ed1);
      chk("m_lane_0",  lane_0, ed0);
      chk("m_valid_0", 32'(valid_0), 32'(ev0));
      chk("m_lane_1",  lane_1, ed1);
      chk("m_valid_1", 32'(valid_1), 32'(ev1));
      chk("m_phase",   32'(phase), 32'(hist.size() % 2));
`ifdef STRIPING_WORD_CNT_EN
      chk("m_count",   32'(word_count), mcnt & 32'h0000_FFFF);
`endif
    end
  end

  task automatic step(input logic r, input logic v, input lane_word_t d);
    reset    = r;
    valid_in = v;
    data_in  = d;
    @(posedge clk_2f);
    #1;
  endtask

  initial begin
    reset    = 1'b0;
    valid_in = 1'b1;
    data_in  = 32'hFFFF_FFFF;
    step(1'b0, 1'b1, 32'hFFFF_FFFF);
    step(1'b0, 1'b1, 32'hFFFF_FFFF);
    chk("rst_lane_0",  lane_0, 32'h0);
    chk("rst_valid_0", 32'(valid_0), 32'h0);
    chk("rst_lane_1",  lane_1, 32'h0);
    chk("rst_valid_1", 32'(valid_1), 32'h0);
    chk("rst_phase",   32'(phase), 32'h0);
`ifdef STRIPING_WORD_CNT_EN
    chk("rst_count",   32'(word_count), 32'h0);
`endif

    step(1'b1, 1'b1, 32'hFFFF_FFFF);
    chk("first_lane_0", lane_0, 32'hFFFF_FFFF);
    chk("first_phase",  32'(phase), 32'h1);
    step(1'b1, 1'b1, 32'hEEEE_EEEE);
    chk("second_lane_1", lane_1, 32'hEEEE_EEEE);
    chk("hold_lane_0",   lane_0, 32'hFFFF_FFFF);
    step(1'b1, 1'b1, 32'hDDDD_DDDD);
    step(1'b1, 1'b1, 32'hCCCC_CCCC);
    chk("burst_lane_0", lane_0, 32'hDDDD_DDDD);
    chk("burst_lane_1", lane_1, 32'hCCCC_CCCC);
`ifdef STRIPING_WORD_CNT_EN
    chk("burst_count", 32'(word_count), 32'h4);
`endif

    step(1'b1, 1'b0, 32'h1234_5678);
    chk("idle_lane_0",  lane_0, 32'h0);
    chk("idle_valid_0", 32'(valid_0), 32'h0);
    chk("idle_keep_1",  lane_1, 32'hCCCC_CCCC);
    step(1'b1, 1'b0, 32'h1234_5678);
    chk("idle_lane_1",  lane_1, 32'h0);
    step(1'b1, 1'b1, 32'h0000_0003);
    step(1'b1, 1'b1, 32'h0000_0004);
    chk("pair_lane_0", lane_0, 32'h3);
    chk("pair_lane_1", lane_1, 32'h4);
    chk("pair_valids", {30'h0, valid_1, valid_0}, 32'h3);

    step(1'b1, 1'b0, 32'h0);
    chk("pre_single_phase", 32'(phase), 32'h1);
    step(1'b1, 1'b1, 32'hA5A5_A5A5);
    chk("single_lane_1",  lane_1, 32'hA5A5_A5A5);
    chk("single_valid_1", 32'(valid_1), 32'h1);
    chk("single_valid_0", 32'(valid_0), 32'h0);
    step(1'b1, 1'b0, 32'h0);
    chk("single_clear_0", lane_0, 32'h0);
    chk("single_hold_1",  lane_1, 32'hA5A5_A5A5);

    step(1'b1, 1'b1, 32'h0000_0011);
    step(1'b1, 1'b1, 32'h0000_0022);
    step(1'b0, 1'b1, 32'h0000_0099);
    chk("midrst_lane_0", lane_0, 32'h0);
    chk("midrst_lane_1", lane_1, 32'h0);
    chk("midrst_valids", {30'h0, valid_1, valid_0}, 32'h0);
    chk("midrst_phase",  32'(phase), 32'h0);
`ifdef STRIPING_WORD_CNT_EN
    chk("midrst_count",  32'(word_count), 32'h0);
`endif
    step(1'b1, 1'b1, 32'h0000_0077);
    chk("restart_lane_0", lane_0, 32'h77);
    chk("restart_lane_1", lane_1, 32'h0);
    chk("restart_phase",  32'(phase), 32'h1);
    step(1'b1, 1'b1, 32'h0000_0088);
    chk("restart_lane_1b", lane_1, 32'h88);

`ifdef STRIPING_WORD_CNT_EN
    step(1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 65535; i++) step(1'b1, 1'b1, 32'(i));
    chk("preset_count", 32'(word_count), 32'h0000_FFFF);
    step(1'b1, 1'b1, 32'hBEEF_0001);
    chk("wrap_count", 32'(word_count), 32'h0);
`endif

    step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
